// File: rtl/ram_delay_mc.sv
// Multi-channel sample-gated delay line on a single inferred read-first RAM.
// Optional macro RAM_DELAY_MC_FILL_EN adds a fill-count output port.
module ram_delay_mc #(
  parameter int P_NBITS_ADDR = 8,
  parameter int P_NBITS_DATA = 14,
  parameter int P_NCHAN      = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [P_NBITS_ADDR-1:0]         n,
  input  logic                            wr,
  input  logic                            prime,
  input  logic [P_NCHAN*P_NBITS_DATA-1:0] d,
  output logic [P_NCHAN*P_NBITS_DATA-1:0] qn,
  output logic [P_NCHAN*P_NBITS_DATA-1:0] qo,
`ifdef RAM_DELAY_MC_FILL_EN
  output logic [P_NBITS_ADDR-1:0]         fill,
`endif
  output logic                            valid
);

  localparam int W     = P_NCHAN * P_NBITS_DATA;
  localparam int DEPTH = 1 << P_NBITS_ADDR;
  localparam logic [P_NBITS_ADDR-1:0] ONE = 1;

  logic [W-1:0]            mem [DEPTH];
  logic [W-1:0]            ram_q;
  logic [W-1:0]            qn_byp;
  logic                    use_ram;
  logic [P_NBITS_ADDR-1:0] n_q;
  logic [P_NBITS_ADDR-1:0] ptr;
  logic [P_NBITS_ADDR-1:0] fill_cnt;

  logic                    restart;
  logic                    bypass;
  logic                    at_full;
  logic                    ram_we;
  logic [P_NBITS_ADDR-1:0] n_eff;
  logic [P_NBITS_ADDR-1:0] ptr_eff;
  logic [P_NBITS_ADDR-1:0] fill_eff;
  logic [P_NBITS_ADDR-1:0] ptr_nxt;

  // A prime or delay change this cycle behaves as if pointer and fill
  // were already cleared, so a coincident wr lands at location 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    restart  = prime | (n != n_q);
    n_eff    = restart ? n : n_q;
    ptr_eff  = restart ? '0 : ptr;
    fill_eff = restart ? '0 : fill_cnt;
    bypass   = (n_eff == '0);
    at_full  = (fill_eff == n_eff);
    ram_we   = wr & ~rst & ~bypass;
    ptr_nxt  = (ptr_eff == n_eff - ONE) ? '0 : ptr_eff + ONE;
  end

  // NOTE: the storage array has no reset; stale contents are masked by valid.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram_q         <= mem[ptr_eff];
      mem[ptr_eff]  <= d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      n_q      <= n;
      ptr      <= '0;
      fill_cnt <= '0;
      qo       <= '0;
      qn_byp   <= '0;
      use_ram  <= 1'b0;
      valid    <= 1'b0;
    end else begin
      n_q      <= n;
      ptr      <= ptr_eff;
      fill_cnt <= fill_eff;
      valid    <= 1'b0;
      if (wr) begin
        qo <= d;
        if (bypass) begin
          qn_byp  <= d;
          use_ram <= 1'b0;
          valid   <= ~restart;
        end else begin
          use_ram <= 1'b1;
          valid   <= at_full;
          ptr     <= ptr_nxt;
          if (!at_full) fill_cnt <= fill_eff + ONE;
        end
      end
    end
  end

  // ram_q only moves on RAM strobes, so the selected source holds between strobes.
  assign qn = use_ram ? ram_q : qn_byp;

`ifdef RAM_DELAY_MC_FILL_EN
  assign fill = fill_cnt;
`endif

endmodule

// File: tb/tb_ram_delay_mc.sv
// Randomized and directed bench for ram_delay_mc against a history-queue model.
module tb_ram_delay_mc;

  localparam int NA = 8;
  localparam int ND = 14;
  localparam int NC = 4;
  localparam int W  = NA * 0 + ND * NC;

  logic          clk = 1'b0;
  logic          rst;
  logic [NA-1:0] n;
  logic          wr;
  logic          prime;
  logic [W-1:0]  d;
  logic [W-1:0]  qn;
  logic [W-1:0]  qo;
  logic          valid;
`ifdef RAM_DELAY_MC_FILL_EN
  logic [NA-1:0] fill;
`endif

  ram_delay_mc #(.P_NBITS_ADDR(NA), .P_NBITS_DATA(ND), .P_NCHAN(NC)) dut (
    .clk   (clk),
    .rst   (rst),
    .n     (n),
    .wr    (wr),
    .prime (prime),
    .d     (d),
    .qn    (qn),
    .qo    (qo),
`ifdef RAM_DELAY_MC_FILL_EN
    .fill  (fill),
`endif
    .valid (valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: every strobe since the last restart, newest at the back.
  logic [W-1:0] hist[$];
  int           m_nq;
  int           m_cnt;
  logic [W-1:0] exp_qn, exp_qo;
  logic         exp_valid;
  bit           qn_known;
  int           valid_seen;

  function automatic logic [W-1:0] rep(input int v);
    logic [W-1:0] r;
    for (int k = 0; k < NC; k++) r[k*ND +: ND] = ND'(v);
    return r;
  endfunction

  function automatic logic [W-1:0] mk(input int i);
    logic [W-1:0] r;
    for (int k = 0; k < NC; k++) r[k*ND +: ND] = ND'(16 * i + k);
    return r;
  endfunction

  task automatic step(input bit rst_i, input bit wr_i, input bit prime_i,
                      input int n_i, input logic [W-1:0] d_i);
    bit restart;
    @(negedge clk);
    rst = rst_i; wr = wr_i; prime = prime_i; n = NA'(n_i); d = d_i;
    @(posedge clk);
    #1;
    if (rst_i) begin
      m_nq = n_i; hist.delete(); m_cnt = 0;
      exp_qn = '0; exp_qo = '0; exp_valid = 1'b0; qn_known = 1;
    end else begin
      restart = prime_i || (n_i != m_nq);
      m_nq = n_i;
      if (restart) begin hist.delete(); m_cnt = 0; end
      exp_valid = 1'b0;
      if (wr_i) begin
        exp_qo = d_i;
        hist.push_back(d_i);
        m_cnt++;
        if (hist.size() > 300) void'(hist.pop_front());
        if (n_i == 0) begin
          exp_qn = d_i; exp_valid = !restart; qn_known = 1;
        end else if (m_cnt > n_i) begin
          exp_qn = hist[hist.size() - 1 - n_i]; exp_valid = 1'b1; qn_known = 1;
        end else begin
          qn_known = 0;
        end
      end
    end
    if (valid === 1'b1) valid_seen++;
    check("valid", 64'(valid), 64'(exp_valid));
    check("qo", 64'(qo), 64'(exp_qo));
    if (qn_known) check("qn", 64'(qn), 64'(exp_qn));
`ifdef RAM_DELAY_MC_FILL_EN
    check("fill", 64'(fill), 64'((m_cnt < m_nq) ? m_cnt : m_nq));
`endif
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; prime = 1'b0; n = 8'd4; d = '0;
    m_nq = 4; m_cnt = 0; exp_qn = '0; exp_qo = '0; exp_valid = 0; qn_known = 1;

    // Reset then fill, n=4
    step(1, 0, 0, 4, '0);
    step(1, 1, 0, 4, mk(99));
    check("rst_qn", 64'(qn), 64'(0));
    for (int i = 0; i < 10; i++) begin
      step(0, 1, 0, 4, mk(i));
      if (i == 4) begin
        check("fill4_qn", 64'(qn), 64'(mk(0)));
        check("fill4_qo", 64'(qo), 64'(mk(4)));
      end
      if (i == 9) check("fill9_ch0", 64'(qn[ND-1:0]), 64'(80));
    end

    // Gapped strobes, n=3
    step(0, 0, 1, 3, '0);
    valid_seen = 0;
    for (int v = 1; v <= 8; v++) begin
      step(0, 1, 0, 3, rep(v));
      step(0, 0, 0, 3, '0);
      step(0, 0, 0, 3, '0);
    end
    check("gap_pulses", 64'(valid_seen), 64'(5));

    // Prime mid-stream, n=5
    for (int i = 0; i < 8; i++) step(0, 1, 0, 5, 64'($urandom));
    step(0, 1, 1, 5, rep(12'hAAA));
    for (int i = 0; i < 4; i++) step(0, 1, 0, 5, 64'($urandom));
    step(0, 1, 0, 5, 64'($urandom));
    check("prime_qn", 64'(qn), 64'(rep(12'hAAA)));
    check("prime_v", 64'(valid), 64'(1));

    // Delay change 8 -> 2 -> 0
    for (int i = 0; i < 12; i++) step(0, 1, 0, 8, mk(i));
    step(0, 0, 0, 2, '0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 2, mk(40 + i));
    check("chg_qn", 64'(qn), 64'(mk(40)));
    step(0, 0, 0, 0, '0);
    for (int i = 0; i < 5; i++) step(0, 1, 0, 0, mk(50 + i));
    check("byp_qn", 64'(qn), 64'(mk(54)));

    // n=1, then n=255 with mid-run reset
    for (int i = 0; i < 6; i++) step(0, 1, 0, 1, mk(60 + i));
    for (int i = 1; i <= 256; i++) step(0, 1, 0, 255, rep(i));
    check("n255_qn", 64'(qn), 64'(rep(1)));
    check("n255_v", 64'(valid), 64'(1));
    step(1, 1, 0, 255, rep(7));
    for (int i = 1; i <= 256; i++) step(0, 1, 0, 255, rep(1000 + i));
    check("rst255_qn", 64'(qn), 64'(rep(1001)));

    // Randomized traffic with occasional prime, delay change and reset
    begin
      int nn, r;
      int n_set[7] = '{0, 1, 2, 3, 5, 17, 255};
      nn = 3;
      for (int c = 0; c < 4000; c++) begin
        r = $urandom_range(0, 999);
        if (r < 10) nn = n_set[$urandom_range(0, 6)];
        step(r >= 995, $urandom_range(0, 9) < 6, (r >= 10 && r < 30),
             nn, {32'($urandom), 32'($urandom)});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_delay_mc.md
Name: ram_delay_mc

Overview:
- Multi-channel, sample-gated delay line built on one inferred single-clock RAM.
- Each write strobe stores P_NCHAN samples and returns the samples written exactly n strobes earlier, for all channels in lockstep.
- Successor to the single-channel delay line. Adds:
  - synchronous reset and channel packing,
  - a prime input and automatic re-prime on delay change,
  - n=0 bypass and fully defined n boundaries.
- Sits between ADC capture/trigger logic and downstream filters/feature extraction.

Parameters:
- P_NBITS_ADDR, 8, RAM address width; RAM depth 2^P_NBITS_ADDR; max delay 2^P_NBITS_ADDR-1.
- P_NBITS_DATA, 14, bits per channel sample.
- P_NCHAN, 4, number of channels; RAM word width P_NCHAN*P_NBITS_DATA.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- n  in  P_NBITS_ADDR  delay length in write strobes; 0 = bypass.
- wr  in  1  sample strobe; only wr cycles advance the line.
- prime  in  1  single-cycle request to invalidate contents and refill.
- d  in  P_NCHAN*P_NBITS_DATA  packed input; channel k at bits [k*P_NBITS_DATA +: P_NBITS_DATA].
- qn  out  P_NCHAN*P_NBITS_DATA  delayed output, same packing.
- qo  out  P_NCHAN*P_NBITS_DATA  undelayed d, time-aligned with qn.
- valid  out  1  one-cycle pulse: qn/qo updated and qn reflects a real n-delayed sample.

Behaviour:
- Reset (rst=1 at clk edge):
  - qn=0, qo=0, valid=0.
  - Write pointer=0, fill count=0, latched delay n_q=n.
  - wr is ignored during reset.
- Storage: circular buffer of n locations, pointer 0..n-1.
  - On wr, read-before-write at the pointer: old word goes to the qn register, d is written.
  - Pointer then increments, wrapping from n-1 to 0.
- Latency:
  - qn, qo and valid update on the clk edge after the wr cycle; fixed 1-cycle latency.
  - qn equals the d of the wr strobe n strobes earlier.
  - qo equals the d of the current strobe.
  - Between strobes, qn/qo hold their values and valid=0.
- Fill counter:
  - Increments on each wr, saturating at n.
  - valid=1 on the cycle after a wr that occurs while fill count == n before increment, i.e. from strobe n+1 onward.
  - For wr strobes 1..n after reset/prime, qn carries stale RAM data and valid=0.
- Prime:
  - prime=1: pointer=0, fill count=0 on that edge.
  - If wr is also asserted that cycle, the sample is written at location 0, fill count becomes 1, and the output for that strobe has valid=0.
- Delay change:
  - Each cycle, n is compared with n_q. On mismatch, n_q<=n and an implicit prime is applied, with the same rules as prime.
  - A wr in the change cycle uses the new n.
- Bypass (n=0): RAM unused; qn=qo=d registered on wr; valid pulses on every wr; no fill phase.
- n=1: one-sample delay; valid from the 2nd strobe.
- Priority: rst > delay change/prime > normal wr.
- Back-to-back wr on every clk is supported at full rate.
- RAM: inferred read-first synchronous block, no external RAM module dependency.
- Widths: pointer and fill count are P_NBITS_ADDR bits; no arithmetic overflow because n ≤ 2^P_NBITS_ADDR-1.

Optional Feature:
- Macro: RAM_DELAY_MC_FILL_EN.
- Defined: adds output port fill [P_NBITS_ADDR-1:0], the current fill count.
  - Registered; 0 after rst/prime/delay change; saturates at n_q.
  - Updates on the same edge as the internal counter.
- Undefined: port absent; all other behaviour identical.

Test Plan:
- Reset then fill: rst 2 cycles, n=4, P_NCHAN=4, wr every cycle, ch k = 16*i+k for strobe i=0..9 -> valid=0 for strobes 0..3; strobe 4 gives valid=1, qn ch k = k, qo ch k = 64+k; strobe 9 qn ch0 = 80.
- Gapped strobes: n=3, wr on every 3rd cycle, d=1..8 -> qn updates only the cycle after each wr; values 1..5 on strobes 4..8; valid pulses exactly 5 times, one cycle wide.
- Prime mid-stream: n=5, steady state, prime with simultaneous wr d=0xAAA -> that output valid=0; next 4 strobes valid=0; 6th strobe after prime has valid=1 and qn=0xAAA.
- Delay change: run n=8, switch to n=2 with no wr -> next two strobes valid=0; 3rd strobe valid=1 with qn = first post-change sample. Switch to n=0 -> qn=qo=d every strobe, valid every strobe.
- Boundaries: n=1 gives qn = previous strobe's d from strobe 2. n=255 (P_NBITS_ADDR=8) gives valid first on strobe 256 with qn = strobe-1 data. rst asserted mid-run deasserts valid next cycle, and 256 further strobes are needed to revalidate.
- With RAM_DELAY_MC_FILL_EN: n=3 -> fill reads 0,1,2,3,3 after successive strobes; 0 the cycle after prime.
